// File: rtl/adder_resp_checker.sv
// Checks an external adder: a+b+ci is delayed LAT cycles and compared with {dut_co,dut_s}.
// One operand per cycle, compare result lands LAT cycles after intake, no backpressure.
module adder_resp_checker #(
   parameter int WIDTH = 32,
   parameter int LAT   = 1,
   parameter int CW    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic [WIDTH-1:0] dut_s,
   input  logic             dut_co,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    pass_cnt,
   output logic [CW-1:0]    fail_cnt,
   output logic             first_fail,
   output logic [WIDTH:0]   ff_exp,
   output logic [WIDTH:0]   ff_got,
   output logic             all_ok
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t         state, state_nxt;
   logic           enter_run;
   logic           accept;
   logic [WIDTH:0] exp_in;
   logic [WIDTH:0] got;
   logic           cmp_fire;
   logic [WIDTH:0] cmp_exp;
   logic           inflight;

   assign enter_run = ((state == IDLE) || (state == DONE)) && start;
   assign accept    = (state == RUN) && in_valid;
   assign exp_in    = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
   assign got       = {dut_co, dut_s};

   generate
      if (LAT == 0) begin : g_lat0
         assign cmp_fire = accept;
         assign cmp_exp  = exp_in;
         assign inflight = 1'b0;
      end else begin : g_pipe
         logic [LAT-1:0] vld;
         logic [WIDTH:0] exp_q [LAT];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld <= '0;
            end else if (enter_run) begin
               vld <= '0;
            end else begin
               vld[0] <= accept;
               for (int i = 1; i < LAT; i++) vld[i] <= vld[i-1];
            end
         end

         // Data stages need no reset: nothing is consumed without its valid bit.
         always_ff @(posedge clk) begin
            exp_q[0] <= exp_in;
            for (int i = 1; i < LAT; i++) exp_q[i] <= exp_q[i-1];
         end

         assign cmp_fire = vld[LAT-1];
         assign cmp_exp  = exp_q[LAT-1];

         // The exiting entry completes this cycle, so only earlier stages keep DRAIN alive.
         if (LAT == 1) begin : g_one
            assign inflight = 1'b0;
         end else begin : g_many
            assign inflight = |vld[LAT-2:0];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = RUN;
         RUN:     if (stop)      state_nxt = DRAIN;
         DRAIN:   if (!inflight) state_nxt = DONE;
         DONE:    if (start)     state_nxt = RUN;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         first_fail <= 1'b0;
         ff_exp     <= '0;
         ff_got     <= '0;
      end else if (enter_run) begin
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         first_fail <= 1'b0;
         ff_exp     <= '0;
         ff_got     <= '0;
      end else if (cmp_fire) begin
         if (cmp_exp == got) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + CW'(1);
         end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CW'(1);
            if (!first_fail) begin
               first_fail <= 1'b1;
               ff_exp     <= cmp_exp;
               ff_got     <= got;
            end
         end
      end
   end

   assign busy   = (state == RUN) || (state == DRAIN);
   assign done   = (state == DONE);
   assign all_ok = done && (fail_cnt == '0) && (pass_cnt != '0);

endmodule

// File: tb/tb_adder_resp_checker.sv
// Three checkers (32b/LAT1/CW16, 8b/LAT3/CW4, 8b/LAT0/CW8) share stimulus; a queue model predicts outputs.
module tb_adder_resp_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, stop = 1'b0, in_valid = 1'b0, ci = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [32:0] err = '0;

   int nvec = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   // Emulated adders under check, with an injectable error mask and per-instance latency.
   logic [32:0] cur32, h32;
   logic [8:0]  cur8;
   logic [8:0]  h8 [3];
   assign cur32 = ({1'b0, a} + {1'b0, b} + 33'(ci)) ^ err;
   assign cur8  = ({1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(ci)) ^ err[8:0];
   always @(posedge clk) begin
      h32   <= cur32;
      h8[0] <= cur8;
      h8[1] <= h8[0];
      h8[2] <= h8[1];
   end

   logic        busy_o [3], done_o [3], ff_o [3], ok_o [3];
   logic [15:0] pc_o [3], fc_o [3];
   logic [32:0] fe_o [3], fg_o [3];

   logic [15:0] pc0, fc0;
   logic [32:0] fe0, fg0;
   logic [3:0]  pc1, fc1;
   logic [8:0]  fe1, fg1, fe2, fg2;
   logic [7:0]  pc2, fc2;

   adder_resp_checker #(.WIDTH(32), .LAT(1), .CW(16)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
      .a(a), .b(b), .ci(ci), .dut_s(h32[31:0]), .dut_co(h32[32]),
      .busy(busy_o[0]), .done(done_o[0]), .pass_cnt(pc0), .fail_cnt(fc0),
      .first_fail(ff_o[0]), .ff_exp(fe0), .ff_got(fg0), .all_ok(ok_o[0]));

   adder_resp_checker #(.WIDTH(8), .LAT(3), .CW(4)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
      .a(a[7:0]), .b(b[7:0]), .ci(ci), .dut_s(h8[2][7:0]), .dut_co(h8[2][8]),
      .busy(busy_o[1]), .done(done_o[1]), .pass_cnt(pc1), .fail_cnt(fc1),
      .first_fail(ff_o[1]), .ff_exp(fe1), .ff_got(fg1), .all_ok(ok_o[1]));

   adder_resp_checker #(.WIDTH(8), .LAT(0), .CW(8)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
      .a(a[7:0]), .b(b[7:0]), .ci(ci), .dut_s(cur8[7:0]), .dut_co(cur8[8]),
      .busy(busy_o[2]), .done(done_o[2]), .pass_cnt(pc2), .fail_cnt(fc2),
      .first_fail(ff_o[2]), .ff_exp(fe2), .ff_got(fg2), .all_ok(ok_o[2]));

   assign pc_o[0] = pc0;            assign fc_o[0] = fc0;
   assign pc_o[1] = {12'b0, pc1};   assign fc_o[1] = {12'b0, fc1};
   assign pc_o[2] = {8'b0, pc2};    assign fc_o[2] = {8'b0, fc2};
   assign fe_o[0] = fe0;            assign fg_o[0] = fg0;
   assign fe_o[1] = {24'b0, fe1};   assign fg_o[1] = {24'b0, fg1};
   assign fe_o[2] = {24'b0, fe2};   assign fg_o[2] = {24'b0, fg2};

   // ---------------- behavioural model ----------------
   localparam int WID [3] = '{32, 8, 8};
   localparam int LT  [3] = '{1, 3, 0};
   localparam logic [63:0] CMAX [3] = '{64'd65535, 64'd15, 64'd255};
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

   typedef struct {
      int          k;
      logic [63:0] e;
      logic [63:0] g;
      int          due;
   } item_t;

   item_t       q [$];
   int          cyc = 0;
   int          ms [3];
   logic [63:0] mp [3], mf [3], mfe [3], mfg [3];
   logic        mff [3];

   task automatic mclear(input int k);
      mp[k] = 0; mf[k] = 0; mff[k] = 1'b0; mfe[k] = 0; mfg[k] = 0;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].k == k) q.delete(i);
   endtask

   task automatic model_step(input int k);
      logic [63:0] m;
      item_t       it;
      int          rem;
      m = (64'd1 << WID[k]) - 64'd1;
      if ((ms[k] == M_IDLE || ms[k] == M_DONE) && start) begin
         mclear(k);
         ms[k] = M_RUN;
         return;
      end
      if (ms[k] != M_RUN && ms[k] != M_DRAIN) return;
      if (ms[k] == M_RUN && in_valid) begin
         it.k   = k;
         it.e   = (64'(a) & m) + (64'(b) & m) + 64'(ci);
         it.g   = it.e ^ (64'(err) & ((m << 1) | 64'd1));
         it.due = cyc + LT[k];
         q.push_back(it);
      end
      rem = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].k == k) begin
            if (q[i].due == cyc) begin
               if (q[i].e == q[i].g) begin
                  if (mp[k] != CMAX[k]) mp[k] = mp[k] + 1;
               end else begin
                  if (mf[k] != CMAX[k]) mf[k] = mf[k] + 1;
                  if (!mff[k]) begin
                     mff[k] = 1'b1; mfe[k] = q[i].e; mfg[k] = q[i].g;
                  end
               end
               q.delete(i);
            end else begin
               rem++;
            end
         end
      end
      if (ms[k] == M_RUN && stop)            ms[k] = M_DRAIN;
      else if (ms[k] == M_DRAIN && rem == 0) ms[k] = M_DONE;
   endtask

   initial for (int k = 0; k < 3; k++) begin
      ms[k] = M_IDLE; mp[k] = 0; mf[k] = 0; mff[k] = 1'b0; mfe[k] = 0; mfg[k] = 0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         for (int k = 0; k < 3; k++) begin
            ms[k] = M_IDLE; mp[k] = 0; mf[k] = 0; mff[k] = 1'b0; mfe[k] = 0; mfg[k] = 0;
         end
      end else begin
         cyc++;
         for (int k = 0; k < 3; k++) model_step(k);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("i%0d busy", k), 64'(busy_o[k]), 64'(ms[k] == M_RUN || ms[k] == M_DRAIN));
         chk($sformatf("i%0d done", k), 64'(done_o[k]), 64'(ms[k] == M_DONE));
         chk($sformatf("i%0d pass_cnt", k), 64'(pc_o[k]), mp[k]);
         chk($sformatf("i%0d fail_cnt", k), 64'(fc_o[k]), mf[k]);
         chk($sformatf("i%0d first_fail", k), 64'(ff_o[k]), 64'(mff[k]));
         chk($sformatf("i%0d ff_exp", k), 64'(fe_o[k]), mfe[k]);
         chk($sformatf("i%0d ff_got", k), 64'(fg_o[k]), mfg[k]);
         chk($sformatf("i%0d all_ok", k), 64'(ok_o[k]),
             64'(ms[k] == M_DONE && mf[k] == 0 && mp[k] != 0));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input logic s, input logic p, input logic v, input logic [31:0] aa,
                      input logic [31:0] bb, input logic c, input logic [32:0] e);
      @(negedge clk);
      start = s; stop = p; in_valid = v; a = aa; b = bb; ci = c; err = e;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 33'd0);
   endtask

   logic [31:0] va [8] = '{32'd37, 32'd125, 32'd63, 32'd122, 32'd245, 32'd3, 32'd100, 32'd127};
   logic [31:0] vb [8] = '{32'd48, 32'd110, 32'd211, 32'd11, 32'd2, 32'd90, 32'd200, 32'd127};
   logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      idle(3);
      chk("reset busy", 64'(busy_o[0]), 64'd0);
      chk("reset pass_cnt", 64'(pc_o[0]), 64'd0);
      chk("reset ff_exp", 64'(fe_o[0]), 64'd0);
      rst_n = 1'b1;
      idle(2);

      // 5 + 10 + 1 = 16
      drv(1, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 1, 32'd5, 32'd10, 1'b1, 33'd0);
      drv(0, 1, 0, 0, 0, 0, 0);
      idle(6);
      chk("single pass_cnt", 64'(pc_o[0]), 64'd1);
      chk("single fail_cnt", 64'(fc_o[0]), 64'd0);
      chk("single done", 64'(done_o[0]), 64'd1);
      chk("single all_ok", 64'(ok_o[0]), 64'd1);

      // eight back-to-back vectors, stop together with the last one
      drv(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) drv(0, i == 7, 1, va[i], vb[i], vc[i], 33'd0);
      idle(6);
      chk("burst8 pass_cnt", 64'(pc_o[0]), 64'd8);
      chk("burst8 fail_cnt", 64'(fc_o[0]), 64'd0);
      chk("burst8 lat3 pass_cnt", 64'(pc_o[1]), 64'd8);

      // 127+127+1 returned as 254, then a second bad vector
      drv(1, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 1, 32'd127, 32'd127, 1'b1, 33'd1);
      drv(0, 1, 1, 32'd1, 32'd1, 1'b0, 33'd4);
      idle(6);
      chk("mismatch fail_cnt", 64'(fc_o[0]), 64'd2);
      chk("mismatch first_fail", 64'(ff_o[0]), 64'd1);
      chk("mismatch ff_exp", 64'(fe_o[0]), 64'd255);
      chk("mismatch ff_got", 64'(fg_o[0]), 64'd254);
      chk("mismatch lat0 ff_got", 64'(fg_o[2]), 64'd254);
      chk("mismatch all_ok", 64'(ok_o[0]), 64'd0);

      // carry-out at full width
      drv(1, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 1, 32'hFFFF_FFFF, 32'd0, 1'b1, 33'd0);
      drv(0, 1, 1, 32'hFFFF_FFFF, 32'd0, 1'b1, 33'h1_0000_0000);
      idle(6);
      chk("carry pass_cnt", 64'(pc_o[0]), 64'd1);
      chk("carry fail_cnt", 64'(fc_o[0]), 64'd1);
      chk("carry ff_exp", 64'(fe_o[0]), 64'h1_0000_0000);
      chk("carry ff_got", 64'(fg_o[0]), 64'd0);

      // LAT=3: stop one cycle after the last vector
      drv(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drv(0, 0, 1, va[i], vb[i], vc[i], 33'd0);
      idle(1);
      drv(0, 1, 0, 0, 0, 0, 0);
      idle(1);
      chk("lat3 busy in drain", 64'(busy_o[1]), 64'd1);
      chk("lat3 pass before last", 64'(pc_o[1]), 64'd2);
      idle(1);
      chk("lat3 done", 64'(done_o[1]), 64'd1);
      chk("lat3 pass_cnt", 64'(pc_o[1]), 64'd3);

      // reset asserted during DRAIN
      drv(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drv(0, i == 2, 1, va[i], vb[i], vc[i], 33'd1);
      idle(1);
      chk("drain before reset", 64'(busy_o[1]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst busy", 64'(busy_o[1]), 64'd0);
      chk("arst done", 64'(done_o[1]), 64'd0);
      chk("arst fail_cnt", 64'(fc_o[0]), 64'd0);
      chk("arst first_fail", 64'(ff_o[0]), 64'd0);
      chk("arst ff_exp", 64'(fe_o[0]), 64'd0);
      chk("arst ff_got", 64'(fg_o[0]), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(5);

      // CW=4 saturation, then restart from DONE
      drv(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) drv(0, i == 19, 1, $urandom, $urandom, 1'($urandom), 33'd0);
      idle(6);
      chk("sat pass_cnt cw4", 64'(pc_o[1]), 64'd15);
      chk("sat pass_cnt cw16", 64'(pc_o[0]), 64'd20);
      drv(1, 0, 0, 0, 0, 0, 0);
      idle(1);
      chk("restart pass_cnt", 64'(pc_o[1]), 64'd0);
      chk("restart busy", 64'(busy_o[1]), 64'd1);
      drv(0, 1, 0, 0, 0, 0, 0);
      idle(6);

      // randomized traffic, including start/stop collisions and occasional resets
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
         start    = ($urandom_range(0, 11) == 0);
         stop     = ($urandom_range(0, 14) == 0);
         in_valid = ($urandom_range(0, 9) < 7);
         a        = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         b        = $urandom;
         ci       = 1'($urandom);
         err      = ($urandom_range(0, 4) == 0) ? (33'd1 << $urandom_range(0, 32)) : 33'd0;
      end
      rst_n = 1'b1;
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
